// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with MIPS load/store decode, lane handling and fault detection.
// After reset the whole array is zeroed one word per cycle before requests are accepted.
module data_memory_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_IDLE  = 1'b1;

    logic             state;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      mem [DEPTH];

    logic             is_load;
    logic             is_store;
    logic             is_signed;
    logic [1:0]       size_code;
    logic [1:0]       offset;
    logic [IDX_W-1:0] idx;
    logic             misaligned;
    logic             out_of_range;
    logic             fault;
    logic             accept;
    logic [31:0]      word;
    logic [15:0]      half_v;
    logic [7:0]       byte_v;
    logic [31:0]      load_value;
    logic [31:0]      store_data;
    logic [3:0]       lane_en;

    assign offset       = address[1:0];
    assign idx          = address[IDX_W+1:2];
    assign out_of_range = (address >> (IDX_W + 2)) != '0;
    assign misaligned   = ((size_code == 2'd2) && (offset != 2'd0)) ||
                          ((size_code == 2'd1) && offset[0]);
    assign fault        = misaligned || out_of_range;
    assign req_ready    = (state == ST_IDLE);
    // Unknown opcodes are swallowed silently: no write and no response strobe.
    assign accept       = req_valid && req_ready && !rst && (is_load || is_store);

    // size_code: 0 = byte, 1 = half, 2 = word
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size_code = 2'd0;
        case (opcode)
            6'b100011: begin is_load  = 1'b1; size_code = 2'd2; end
            6'b100001: begin is_load  = 1'b1; size_code = 2'd1; is_signed = 1'b1; end
            6'b100101: begin is_load  = 1'b1; size_code = 2'd1; end
            6'b100000: begin is_load  = 1'b1; size_code = 2'd0; is_signed = 1'b1; end
            6'b100100: begin is_load  = 1'b1; size_code = 2'd0; end
            6'b101011: begin is_store = 1'b1; size_code = 2'd2; end
            6'b101001: begin is_store = 1'b1; size_code = 2'd1; end
            6'b101000: begin is_store = 1'b1; size_code = 2'd0; end
            default:   ;
        endcase
    end

    assign word   = mem[idx];
    assign half_v = offset[1] ? word[31:16] : word[15:0];
    assign byte_v = word[{offset, 3'b000} +: 8];

    always_comb begin
        load_value = '0;
        case (size_code)
            2'd2:    load_value = word;
            2'd1:    load_value = is_signed ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            default: load_value = is_signed ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
        endcase
    end

    // Store data is replicated across lanes so the lane enables alone pick the target bytes.
    always_comb begin
        lane_en    = 4'b0001 << offset;
        store_data = {4{wdata[7:0]}};
        case (size_code)
            2'd2: begin
                lane_en    = 4'b1111;
                store_data = wdata;
            end
            2'd1: begin
                lane_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (accept && is_store && !fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i]) begin
                        mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            rsp_valid <= accept;
            err       <= accept && fault;
            rdata     <= (accept && is_load && !fault) ? load_value : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed plus randomized bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int BYTES  = DEPTH * 4;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic              rsp_valid;
    logic [31:0]       rdata;
    logic              err;

    int errors;
    int checks;

    logic [7:0] model_mem [BYTES];

    data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .address   (address),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
    endtask

    // Reference behaviour: memory as a flat little-endian byte array.
    task automatic modelAccess(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                               output logic rv, output logic e, output logic [31:0] rd);
        int     size;
        bit     ld;
        bit     sg;
        bit     flt;
        longint v;
        size = 0; ld = 0; sg = 0;
        rv = 1'b0; e = 1'b0; rd = 32'h0;
        case (op)
            OP_LW:  begin size = 4; ld = 1; end
            OP_LH:  begin size = 2; ld = 1; sg = 1; end
            OP_LHU: begin size = 2; ld = 1; end
            OP_LB:  begin size = 1; ld = 1; sg = 1; end
            OP_LBU: begin size = 1; ld = 1; end
            OP_SW:  size = 4;
            OP_SH:  size = 2;
            OP_SB:  size = 1;
            default: size = 0;
        endcase
        if (size != 0) begin
            flt = ((longint'(addr) % size) != 0) || (longint'(addr) >= longint'(BYTES));
            rv = 1'b1;
            e  = flt;
            if (!flt && !ld) begin
                for (int b = 0; b < size; b++) model_mem[addr + b] = wd[8*b +: 8];
            end else if (!flt && ld) begin
                v = 0;
                for (int b = 0; b < size; b++) v = v + (longint'(model_mem[addr + b]) << (8 * b));
                if (sg && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endtask

    // One request in IDLE; the response is sampled just after the acceptance edge.
    task automatic applyStimulus(input string tag, input logic valid, input logic [5:0] op,
                                 input logic [31:0] addr, input logic [31:0] wd);
        logic       rv;
        logic       e;
        logic [31:0] rd;
        req_valid = valid;
        opcode    = op;
        address   = addr;
        wdata     = wd;
        checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        if (valid) modelAccess(op, addr, wd, rv, e, rd);
        else begin rv = 1'b0; e = 1'b0; rd = 32'h0; end
        checkOutput({tag, ".rsp_valid"}, {31'b0, rsp_valid}, {31'b0, rv});
        checkOutput({tag, ".err"},       {31'b0, err},       {31'b0, e});
        checkOutput({tag, ".rdata"},     rdata,              rd);
        req_valid = 1'b0;
    endtask

    // Releases reset and counts cycles until ready, offering a store the whole time.
    task automatic waitClear(input string tag);
        int n;
        n   = 0;
        rst = 1'b0;
        req_valid = 1'b1;
        opcode    = OP_SW;
        address   = 32'h0;
        wdata     = 32'hFFFF_FFFF;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            checkOutput({tag, ".clear_no_rsp"}, {31'b0, rsp_valid}, 32'h0);
        end
        req_valid = 1'b0;
        checkOutput({tag, ".clear_cycles"}, 32'(n), 32'(DEPTH));
        modelClear();
    endtask

    logic [5:0] op_table [10];

    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        logic        valid;

        errors = 0;
        checks = 0;
        op_table = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'b000000, 6'b001000};
        rst       = 1'b1;
        req_valid = 1'b0;
        opcode    = 6'b0;
        address   = '0;
        wdata     = '0;
        modelClear();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.ready",     {31'b0, req_ready}, 32'h0);
        checkOutput("reset.rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset.err",       {31'b0, err},       32'h0);
        checkOutput("reset.rdata",     rdata,              32'h0);

        waitClear("clear1");
        applyStimulus("lw_top", 1'b1, OP_LW, 32'h3C, 32'h0);
        for (int w = 0; w < DEPTH; w++) applyStimulus("zero_scan", 1'b1, OP_LW, 32'(w * 4), 32'h0);

        applyStimulus("sw_deadbeef", 1'b1, OP_SW, 32'h8, 32'hDEAD_BEEF);
        applyStimulus("lw_deadbeef", 1'b1, OP_LW, 32'h8, 32'h0);
        checkOutput("lw_deadbeef.const", rdata, 32'hDEAD_BEEF);

        applyStimulus("sw_zero", 1'b1, OP_SW, 32'h8, 32'h0);
        applyStimulus("sb_80",   1'b1, OP_SB, 32'h9, 32'h0000_0080);
        applyStimulus("lw_8000", 1'b1, OP_LW, 32'h8, 32'h0);
        checkOutput("lw_8000.const", rdata, 32'h0000_8000);
        applyStimulus("lb_80",   1'b1, OP_LB, 32'h9, 32'h0);
        checkOutput("lb_80.const", rdata, 32'hFFFF_FF80);
        applyStimulus("lbu_80",  1'b1, OP_LBU, 32'h9, 32'h0);
        checkOutput("lbu_80.const", rdata, 32'h0000_0080);
        applyStimulus("sh_1234", 1'b1, OP_SH, 32'hA, 32'h0000_1234);
        applyStimulus("lw_1234", 1'b1, OP_LW, 32'h8, 32'h0);
        checkOutput("lw_1234.const", rdata, 32'h1234_8000);
        applyStimulus("lh_1234", 1'b1, OP_LH, 32'hA, 32'h0);
        applyStimulus("sh_neg",  1'b1, OP_SH, 32'h4, 32'h0000_F00D);
        applyStimulus("lh_neg",  1'b1, OP_LH, 32'h4, 32'h0);
        applyStimulus("lhu_neg", 1'b1, OP_LHU, 32'h4, 32'h0);

        applyStimulus("lw_misal", 1'b1, OP_LW, 32'h2, 32'h0);
        checkOutput("lw_misal.err_const", {31'b0, err}, 32'h1);
        applyStimulus("sh_misal", 1'b1, OP_SH, 32'h5, 32'h0000_5555);
        applyStimulus("lw_word1", 1'b1, OP_LW, 32'h4, 32'h0);
        applyStimulus("sw_oor",   1'b1, OP_SW, 32'(BYTES), 32'h1111_1111);
        applyStimulus("sw_oor_hi", 1'b1, OP_SW, 32'h8000_0000, 32'h2222_2222);
        applyStimulus("lw_word0", 1'b1, OP_LW, 32'h0, 32'h0);
        applyStimulus("nop_op",   1'b1, 6'b000000, 32'h0, 32'h0);
        applyStimulus("idle",     1'b0, OP_LW, 32'h0, 32'h0);

        for (int k = 0; k < 400; k++) begin
            valid = ($urandom_range(0, 9) != 0);
            op    = op_table[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) addr = $urandom();
            else addr = 32'($urandom_range(0, BYTES + 7));
            applyStimulus("random", valid, op, addr, $urandom());
        end
        for (int w = 0; w < DEPTH; w++) applyStimulus("final_scan", 1'b1, OP_LW, 32'(w * 4), 32'h0);

        // An in-flight response and a store coinciding with reset must both vanish.
        req_valid = 1'b1;
        opcode    = OP_LW;
        address   = 32'h8;
        @(posedge clk);
        #1;
        checkOutput("inflight.rsp", {31'b0, rsp_valid}, 32'h1);
        opcode    = OP_SW;
        wdata     = 32'hCAFE_F00D;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rst_store.rsp",   {31'b0, rsp_valid}, 32'h0);
        checkOutput("rst_store.rdata", rdata,              32'h0);
        checkOutput("rst_store.ready", {31'b0, req_ready}, 32'h0);

        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midclear.ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midclear.rsp", {31'b0, rsp_valid}, 32'h0);
        waitClear("clear2");
        for (int w = 0; w < DEPTH; w++) applyStimulus("post_scan", 1'b1, OP_LW, 32'(w * 4), 32'h0);

        $display("[TB] directed and random sequence complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
